// File: rtl/parity_link_pkg.sv
// parity_link_pkg: line states, line levels and the parity function used by both ends of the link.
// Contents: state_t (IDLE/START/DATA/PARITY/STOP), START_LVL/STOP_LVL/IDLE_LVL, parity_bit(word, odd).
package parity_link_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  localparam logic IDLE_LVL = 1'b1;
  // Words are zero-extended to this width; the extra zeros leave the XOR unchanged.
  localparam int PAR_MAX_W = 64;
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] word, input logic odd);
    return ^word ^ odd;
  endfunction
endpackage

// File: rtl/bit_period_timer.sv
// bit_period_timer: counts clocks within one serial bit period.
// Ports: clk, rst (async, active-high), restart (hold at the period's first clock),
// tick (last clock of the period), tick_next (the following clock is the last of the period).
module bit_period_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next
);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
  assign tick = cnt == LAST;
  // With one clock per bit every clock is the last one, so the next clock is too.
  assign tick_next = BIT_CYCLES == 1 || cnt == CW'(BIT_CYCLES - 2);
endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: parity-protected serial transmitter (start, data LSB first, parity, stop).
// Ports: clk, rst (async, active-high), data_in/load (accept when load && ready),
// ready (idle), tx_out (serial line, idle 1), tx_busy (frame in progress), frame_done (last stop clock).
module parity_serial_tx
  import parity_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD_PARITY = 0,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  state_t state;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [IW-1:0] idx;
  logic par, tick, tick_next;
  bit_period_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .restart(state == IDLE),
    .tick(tick),
    .tick_next(tick_next)
  );
  assign shift_nxt = shift >> 1;
  // Outputs are registered, so each one is set at the edge that enters the cycle it describes.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      par <= 1'b0;
      ready <= 1'b1;
      tx_busy <= 1'b0;
      tx_out <= IDLE_LVL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state <= START;
          shift <= data_in;
          idx <= '0;
          ready <= 1'b0;
          tx_busy <= 1'b1;
          tx_out <= START_LVL;
        end
        START: if (tick) begin
          state <= DATA;
          par <= parity_bit(PAR_MAX_W'(shift), ODD_PARITY != 0);
          tx_out <= shift[0];
        end
        DATA: if (tick) begin
          idx <= idx + 1'b1;
          shift <= shift_nxt;
          tx_out <= idx == LAST_IDX ? par : shift_nxt[0];
          if (idx == LAST_IDX) state <= PARITY;
        end
        PARITY: begin
          frame_done <= tick && tick_next;
          if (tick) begin
            state <= STOP;
            tx_out <= STOP_LVL;
          end
        end
        STOP: begin
          frame_done <= !tick && tick_next;
          if (tick) begin
            state <= IDLE;
            ready <= 1'b1;
            tx_busy <= 1'b0;
            tx_out <= IDLE_LVL;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: directed self-checking bench for parity_serial_tx.
module tb_parity_serial_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] data_e = '0, data_o = '0;
  logic [2:0] data_s = '0;
  logic load_e = 1'b0, load_o = 1'b0, load_s = 1'b0;
  logic ready_e, tx_e, busy_e, done_e;
  logic ready_o, tx_o, busy_o, done_o;
  logic ready_s, tx_s, busy_s, done_s;
  int tests = 0, fails = 0;

  parity_serial_tx #(.DATA_W(8), .ODD_PARITY(0), .BIT_CYCLES(4)) u_even (
    .clk(clk), .rst(rst), .data_in(data_e), .load(load_e),
    .ready(ready_e), .tx_out(tx_e), .tx_busy(busy_e), .frame_done(done_e));
  parity_serial_tx #(.DATA_W(8), .ODD_PARITY(1), .BIT_CYCLES(4)) u_odd (
    .clk(clk), .rst(rst), .data_in(data_o), .load(load_o),
    .ready(ready_o), .tx_out(tx_o), .tx_busy(busy_o), .frame_done(done_o));
  parity_serial_tx #(.DATA_W(3), .ODD_PARITY(0), .BIT_CYCLES(1)) u_small (
    .clk(clk), .rst(rst), .data_in(data_s), .load(load_s),
    .ready(ready_s), .tx_out(tx_s), .tx_busy(busy_s), .frame_done(done_s));

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({tx_e, ready_e, busy_e, done_e} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_even got %b want 1100", {tx_e, ready_e, busy_e, done_e});
    end
    tests++;
    if ({tx_o, ready_o, busy_o, done_o, tx_s, ready_s, busy_s, done_s} !== 8'b11001100) begin
      fails++;
      $display("FAIL reset_odd_small got %b want 11001100",
               {tx_o, ready_o, busy_o, done_o, tx_s, ready_s, busy_s, done_s});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({tx_e, ready_e, busy_e} !== 3'b110) begin
        fails++;
        $display("FAIL reset_idle_line clk %0d got %b want 110", i, {tx_e, ready_e, busy_e});
      end
    end
  endtask

  task automatic test_even_a5();
    logic [10:0] seq = 11'b1_0_10100101_0;
    logic [3:0] exp;
    @(negedge clk);
    data_e = 8'hA5;
    load_e = 1'b1;
    @(posedge clk);
    #1 load_e = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      exp = c <= 44 ? {seq[(c-1)/4], c == 44, 1'b1, 1'b0} : 4'b1001;
      tests++;
      if ({tx_e, done_e, busy_e, ready_e} !== exp) begin
        fails++;
        $display("FAIL even_a5 clk %0d tx/done/busy/ready got %b want %b", c, {tx_e, done_e, busy_e, ready_e}, exp);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] seq = 11'b1_0_10100101_0;
    logic [3:0] exp;
    @(negedge clk);
    data_e = 8'hA5;
    load_e = 1'b1;
    @(posedge clk);
    #1 load_e = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      exp = c <= 44 ? {seq[(c-1)/4], c == 44, 1'b1, 1'b0} : 4'b1001;
      tests++;
      if ({tx_e, done_e, busy_e, ready_e} !== exp) begin
        fails++;
        $display("FAIL busy_ignore clk %0d tx/done/busy/ready got %b want %b", c, {tx_e, done_e, busy_e, ready_e}, exp);
      end
      if (c == 10) begin
        data_e = 8'h3C;
        load_e = 1'b1;
      end
      if (c == 11) load_e = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seq1 = 11'b1_0_10100101_0;
    logic [10:0] seq2 = 11'b1_0_00111100_0;
    logic [3:0] exp;
    @(negedge clk);
    data_e = 8'hA5;
    load_e = 1'b1;
    @(posedge clk);
    #1 data_e = 8'h3C;
    for (int c = 1; c <= 91; c++) begin
      @(negedge clk);
      exp = c <= 44 ? {seq1[(c-1)/4], c == 44, 1'b1, 1'b0} :
            c == 45 ? 4'b1001 :
            c <= 89 ? {seq2[(c-46)/4], c == 89, 1'b1, 1'b0} : 4'b1001;
      tests++;
      if ({tx_e, done_e, busy_e, ready_e} !== exp) begin
        fails++;
        $display("FAIL back_to_back clk %0d tx/done/busy/ready got %b want %b", c, {tx_e, done_e, busy_e, ready_e}, exp);
      end
      if (c == 46) load_e = 1'b0;
    end
  endtask

  task automatic test_parity(input logic odd, input logic [7:0] d, input logic exp_p);
    logic [10:0] bits = '0;
    int done_at = -1;
    @(negedge clk);
    if (odd) begin
      data_o = d;
      load_o = 1'b1;
    end else begin
      data_e = d;
      load_e = 1'b1;
    end
    @(posedge clk);
    #1 begin
      load_o = 1'b0;
      load_e = 1'b0;
    end
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if ((c - 1) % 4 == 1 && c <= 44) bits[(c-1)/4] = odd ? tx_o : tx_e;
      if ((odd ? done_o : done_e) === 1'b1) done_at = c;
    end
    tests++;
    if (bits[9] !== exp_p) begin
      fails++;
      $display("FAIL parity_bit odd=%0d data=%h got %b want %b", odd, d, bits[9], exp_p);
    end
    tests++;
    if ((^bits[9:1]) !== odd) begin
      fails++;
      $display("FAIL parity_check odd=%0d data=%h xor got %b want %b", odd, d, ^bits[9:1], odd);
    end
    tests++;
    if ({bits[10], bits[0], 8'(done_at)} !== {2'b10, 8'd44}) begin
      fails++;
      $display("FAIL parity_framing odd=%0d start/stop %b%b done_at %0d want 0/1 and 44", odd, bits[0], bits[10], done_at);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] seq = 11'b1_0_10000001_0;
    logic [3:0] exp;
    @(negedge clk);
    data_e = 8'hA5;
    load_e = 1'b1;
    @(posedge clk);
    #1 load_e = 1'b0;
    repeat (18) @(negedge clk);
    tests++;
    if (tx_e !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_pre data bit3 got %b want 0", tx_e);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({tx_e, ready_e, busy_e, done_e} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_mid_async got %b want 1100", {tx_e, ready_e, busy_e, done_e});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    data_e = 8'h81;
    load_e = 1'b1;
    @(posedge clk);
    #1 load_e = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      exp = c <= 44 ? {seq[(c-1)/4], c == 44, 1'b1, 1'b0} : 4'b1001;
      tests++;
      if ({tx_e, done_e, busy_e, ready_e} !== exp) begin
        fails++;
        $display("FAIL reset_mid_81 clk %0d tx/done/busy/ready got %b want %b", c, {tx_e, done_e, busy_e, ready_e}, exp);
      end
    end
  endtask

  task automatic test_small();
    logic [5:0] seq = 6'b101100;
    logic [3:0] exp;
    @(negedge clk);
    data_s = 3'b110;
    load_s = 1'b1;
    @(posedge clk);
    #1 load_s = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp = c <= 6 ? {seq[c-1], c == 6, 1'b1, 1'b0} : 4'b1001;
      tests++;
      if ({tx_s, done_s, busy_s, ready_s} !== exp) begin
        fails++;
        $display("FAIL small_bc1 clk %0d tx/done/busy/ready got %b want %b", c, {tx_s, done_s, busy_s, ready_s}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_a5();
    test_busy_ignore();
    test_back_to_back();
    test_parity(1'b0, 8'h07, 1'b1);
    test_parity(1'b1, 8'h07, 1'b0);
    test_parity(1'b1, 8'h00, 1'b1);
    test_reset_mid();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
